// File: rtl/ram_sp_bytewr_clr.sv
// ram_sp_bytewr_clr: single-port byte-write RAM with read strobe/valid, read-during-write mode, optional output register and clear sequencer
module ram_sp_bytewr_clr #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int READ_MODE = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_Address,
  input  logic [DATA_W-1:0]     i_DataIn,
  input  logic                  i_WR,
  input  logic [DATA_W/8-1:0]   i_ByteEn,
  input  logic                  i_RD,
  input  logic                  i_Clear,
  output logic [DATA_W-1:0]     o_DataOut,
  output logic                  o_Valid,
  output logic                  o_Busy
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word, merged, rd_word, p_data, out_d;
  logic p_valid, out_v, idle, wr, rd;
  assign idle = state == IDLE && !i_Clear;
  assign wr = idle && i_WR;
  assign rd = idle && i_RD;
  assign old_word = mem[i_Address];
  assign rd_word = READ_MODE != 0 ? merged : old_word;
  assign o_Busy = rst || state == CLEAR;
  assign out_v = OUT_REG != 0 ? p_valid : rd;
  assign out_d = OUT_REG != 0 ? p_data : rd_word;
  always_comb begin
    merged = old_word;
    for (int k = 0; k < NB; k++)
      if (i_ByteEn[k]) merged[8*k +: 8] = i_DataIn[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr) mem[i_Address] <= merged;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      state <= &cnt ? IDLE : CLEAR;
    end else if (i_Clear) begin
      state <= CLEAR;
      cnt <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_data <= '0;
      o_Valid <= 1'b0;
      o_DataOut <= '0;
    end else begin
      p_valid <= rd;
      if (rd) p_data <= rd_word;
      o_Valid <= out_v;
      if (out_v) o_DataOut <= out_d;
    end
  end
endmodule

// File: tb/tb_ram_sp_bytewr_clr.sv
// tb_ram_sp_bytewr_clr: scoreboard bench driving three RAM configurations with shared stimulus
module tb_ram_sp_bytewr_clr;
  typedef struct {int due; logic [15:0] d;} exp_t;
  typedef struct {logic [3:0] a; logic [15:0] d; logic w; logic [1:0] be; logic rd; logic [15:0] e0; logic [15:0] e1;} vec_t;
  logic clk = 1'b0;
  logic rst, wr, rd, clr;
  logic [3:0] addr;
  logic [15:0] din;
  logic [1:0] be;
  logic [2:0][15:0] dout;
  logic [2:0] val, bsy;
  exp_t q [3][$];
  logic [15:0] last [3];
  logic [15:0] mm [16];
  logic mbusy = 1'b1;
  int mcnt = 0;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  vec_t tbl [14];
  always #5 clk = ~clk;
  ram_sp_bytewr_clr #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .i_Address(addr), .i_DataIn(din), .i_WR(wr), .i_ByteEn(be),
    .i_RD(rd), .i_Clear(clr), .o_DataOut(dout[0]), .o_Valid(val[0]), .o_Busy(bsy[0]));
  ram_sp_bytewr_clr #(.DATA_W(16), .ADDR_W(4), .READ_MODE(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .i_Address(addr), .i_DataIn(din), .i_WR(wr), .i_ByteEn(be),
    .i_RD(rd), .i_Clear(clr), .o_DataOut(dout[1]), .o_Valid(val[1]), .o_Busy(bsy[1]));
  ram_sp_bytewr_clr #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .OUT_REG(1)) u_or (
    .clk(clk), .rst(rst), .i_Address(addr), .i_DataIn(din), .i_WR(wr), .i_ByteEn(be),
    .i_RD(rd), .i_Clear(clr), .o_DataOut(dout[2]), .o_Valid(val[2]), .o_Busy(bsy[2]));
  task automatic cmp(input string n, input int i, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, i, cyc, act, exp);
    end
  endtask
  task automatic check();
    exp_t e;
    logic ev;
    for (int i = 0; i < 3; i++) begin
      ev = q[i].size() > 0 && q[i][0].due == cyc;
      if (ev) begin
        e = q[i].pop_front();
        last[i] = e.d;
      end
      cmp("busy", i, {15'b0, bsy[i]}, {15'b0, mbusy});
      cmp("valid", i, {15'b0, val[i]}, {15'b0, ev});
      cmp("data", i, dout[i], last[i]);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] a, input logic [15:0] d, input logic w,
                      input logic [1:0] b, input logic rd_i, input logic c, input logic ue,
                      input logic [15:0] e0, input logic [15:0] e1);
    logic [15:0] old, mrg;
    exp_t e;
    rst = r; addr = a; din = d; wr = w; be = b; rd = rd_i; clr = c;
    old = mm[a];
    mrg = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    if (r) begin
      mbusy = 1'b1;
      mcnt = 0;
      for (int i = 0; i < 3; i++) begin
        q[i].delete();
        last[i] = 16'h0;
      end
    end else if (mbusy) begin
      mm[mcnt] = 16'h0;
      if (mcnt == 15) mbusy = 1'b0;
      mcnt++;
    end else if (c) begin
      mbusy = 1'b1;
      mcnt = 0;
    end else begin
      if (rd_i) begin
        e.due = cyc + 1; e.d = ue ? e0 : old; q[0].push_back(e);
        e.d = ue ? e1 : mrg; q[1].push_back(e);
        e.due = cyc + 2; e.d = ue ? e0 : old; q[2].push_back(e);
      end
      if (w) mm[a] = mrg;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd_all();
    for (int a = 0; a < 16; a++) step(0, a[3:0], 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);
  endtask
  initial begin
    tbl[0]  = '{4'd3, 16'hA5C3, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0};
    tbl[1]  = '{4'd3, 16'hFF00, 1'b1, 2'b10, 1'b0, 16'h0, 16'h0};
    tbl[2]  = '{4'd3, 16'h0000, 1'b0, 2'b00, 1'b1, 16'hFFC3, 16'hFFC3};
    tbl[3]  = '{4'd3, 16'h1234, 1'b1, 2'b00, 1'b0, 16'h0, 16'h0};
    tbl[4]  = '{4'd3, 16'h0000, 1'b0, 2'b00, 1'b1, 16'hFFC3, 16'hFFC3};
    tbl[5]  = '{4'd5, 16'h1234, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0};
    tbl[6]  = '{4'd5, 16'hBEEF, 1'b1, 2'b01, 1'b1, 16'h1234, 16'h12EF};
    tbl[7]  = '{4'd5, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h12EF, 16'h12EF};
    tbl[8]  = '{4'd1, 16'h1111, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0};
    tbl[9]  = '{4'd2, 16'h2222, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0};
    tbl[10] = '{4'd3, 16'h3333, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0};
    tbl[11] = '{4'd1, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h1111, 16'h1111};
    tbl[12] = '{4'd2, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h2222, 16'h2222};
    tbl[13] = '{4'd3, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h3333, 16'h3333};
    for (int i = 0; i < 16; i++) mm[i] = 16'h0;
    for (int i = 0; i < 3; i++) last[i] = 16'h0;
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, i[3:0], 16'hFFFF, 1, 2'b11, 1, 1, 0, 0, 0);
    rd_all();
    for (int i = 0; i < 14; i++) step(0, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].be, tbl[i].rd, 0, 1, tbl[i].e0, tbl[i].e1);
    idle(2);
    for (int a = 0; a < 16; a++) step(0, a[3:0], 16'hFFFF, 1, 2'b11, 0, 0, 0, 0, 0);
    step(0, 4'd7, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 4'd0, 16'h1234, 1, 2'b11, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, i[3:0], 16'h5555, 1, 2'b11, 1, 0, 0, 0, 0);
    rd_all();
    step(0, 4'd9, 16'hABCD, 1, 2'b11, 0, 0, 0, 0, 0);
    step(0, 4'd9, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 4'd9, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(17);
    step(0, 4'd9, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ram_sp_bytewr_clr.md
Name: ram_sp_bytewr_clr

Overview:
- Parametrised single-port synchronous RAM for the micro's data memory.
- Successor to the fixed 8-bit x 256 data RAM.
- Adds configurable width and depth, per-byte write enables, and an explicit read strobe with a valid flag.
- Adds selectable read-during-write mode, an optional output register, and a hardware clear sequencer that zeroes the array after reset or on request.

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words.
- READ_MODE, 0: 0 = read-first (simultaneous read returns old word); 1 = write-first (returns newly merged word).
- OUT_REG, 0: 0 = read latency 1 cycle; 1 = extra output pipeline stage, latency 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_Address  in  ADDR_W  word address.
- i_DataIn  in  DATA_W  write data.
- i_WR  in  1  write strobe.
- i_ByteEn  in  NB  byte-lane write enables; bit k covers bits [8k+7:8k].
- i_RD  in  1  read strobe.
- i_Clear  in  1  start array clear (single-cycle pulse sufficient).
- o_DataOut  out  DATA_W  read data; holds last read value between reads.
- o_Valid  out  1  one-cycle pulse, aligned with o_DataOut update.
- o_Busy  out  1  high while clear sequence runs; accesses ignored.

Behaviour:
Reset:
- While rst=1: o_DataOut=0, o_Valid=0, o_Busy=1.
- The FSM is held in CLEAR with the clear counter at 0. No array writes occur during reset.
- Any output-pipeline register is also zeroed.

FSM states: CLEAR, IDLE.

CLEAR:
- Each edge with rst=0 writes 0 to mem[cnt] and increments cnt.
- On the edge that writes mem[DEPTH-1], the FSM moves to IDLE and o_Busy goes to 0.
- o_Busy is therefore high for exactly DEPTH cycles after rst deasserts.
- i_WR, i_RD and i_Clear are ignored in CLEAR; o_Valid stays 0.
- rst asserted mid-clear restarts the sequence from cnt=0.

IDLE, i_Clear=1:
- The FSM moves to CLEAR with cnt=0 and o_Busy=1 on the next edge.
- i_Clear has priority: a simultaneous i_WR/i_RD in that cycle is dropped, with no write and no o_Valid.

IDLE, i_WR=1:
- For each lane k with i_ByteEn[k]=1, mem[addr] lane k is set from i_DataIn lane k on the edge. Other lanes are unchanged.
- i_ByteEn=0 means no array change.

IDLE, i_RD=1:
- OUT_REG=0: o_DataOut = word and o_Valid=1 one edge later.
- OUT_REG=1: the same update occurs two edges later.
- Back-to-back reads are fully pipelined: one result per cycle, in order.

IDLE, i_RD=1 and i_WR=1 (same address by definition):
- READ_MODE=0: returns the pre-write word.
- READ_MODE=1: returns the post-write merged word, i.e. enabled lanes from i_DataIn and the rest from the old word.

In-flight reads and clear:
- A read issued the cycle before a clear starts still completes with o_Valid on schedule.
- A read still in the OUT_REG stage when rst asserts is discarded.

Address wrap: ADDR_W fully decodes DEPTH, so there are no out-of-range addresses.

o_DataOut is never cleared by i_Clear; only rst zeroes it.

Test Plan:
Configuration for all scenarios: DATA_W=16, ADDR_W=4, OUT_REG=0 unless noted.
- Reset/clear: pulse rst 2 cycles, release -> o_Busy=1 for exactly 16 cycles then 0; reads of addr 0..15 return 0x0000 with o_Valid one cycle after each i_RD.
- Byte enables: write 0xA5C3 ByteEn=2'b11 addr 3, then 0xFF00 ByteEn=2'b10 addr 3, then read addr 3 -> 0xFFC3; write with ByteEn=2'b00 leaves 0xFFC3.
- Read-during-write: addr 5 holds 0x1234; i_WR+i_RD same cycle, data 0xBEEF, ByteEn=2'b01 -> READ_MODE=0 returns 0x1234, READ_MODE=1 returns 0x12EF; subsequent read returns 0x12EF in both modes.
- Pipelined reads, OUT_REG=1: i_RD on addrs 1,2,3 in consecutive cycles -> o_Valid high for 3 consecutive cycles starting 2 edges after first i_RD, data in order.
- Runtime clear: fill all words 0xFFFF, pulse i_Clear with simultaneous i_WR to addr 0 -> write dropped, o_Busy high 16 cycles, i_RD during busy gives no o_Valid; afterwards all words read 0x0000.
- Reset mid-clear: assert rst at clear cycle 7 for 1 cycle -> o_Busy stays high, full 16-cycle clear reruns, o_DataOut=0 after reset.
